// File: rtl/uart_tx_frame_arb.sv
// rtl/uart_tx_frame_arb.sv - round-robin arbiter sharing one UART TX between frame sources
// Winner's frame is captured on grant and sent MSB byte first via trmt/tx_done.
module uart_tx_frame_arb #(
  parameter int NUM_REQ   = 2,
  parameter int FRM_BYTES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*FRM_BYTES*8-1:0] frm_data,
  input  logic                           tx_done,
  output logic                           trmt,
  output logic [7:0]                     tx_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             frm_cmplt,
  output logic                           busy
);

  localparam int FW = FRM_BYTES * 8;
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (FRM_BYTES > 1) ? $clog2(FRM_BYTES) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d;
  logic [PW-1:0]      win, cand;
  logic               found;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FW-1:0]      shift_q, shift_d;
  logic               trmt_q, trmt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, cmplt_q, cmplt_d;

  // First set request at or after ptr, wrapping to lower indices.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PW'((int'(ptr_q) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    gnt_d   = gnt_q;
    trmt_d  = 1'b0;
    cmplt_d = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = ONE << win;
          owner_d = win;
          shift_d = frm_data[win*FW +: FW];
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        trmt_d  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (cnt_q == CW'(FRM_BYTES - 1)) begin
            cmplt_d = ONE << owner_q;
            gnt_d   = '0;
            ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_d = IDLE;
          end else begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      trmt_q  <= 1'b0;
      gnt_q   <= '0;
      cmplt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      trmt_q  <= trmt_d;
      gnt_q   <= gnt_d;
      cmplt_q <= cmplt_d;
    end
  end

  assign trmt      = trmt_q;
  assign tx_data   = shift_q[FW-1 -: 8];
  assign gnt       = gnt_q;
  assign frm_cmplt = cmplt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_frame_arb.sv
// tb/tb_uart_tx_frame_arb.sv - self-checking bench for uart_tx_frame_arb
module tb_uart_tx_frame_arb;

  localparam int N  = 2;
  localparam int B  = 2;
  localparam int FW = B * 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*FW-1:0]  frm_data = '0;
  logic             tx_done = 1'b0;
  logic             trmt;
  logic [7:0]       tx_data;
  logic [N-1:0]     gnt;
  logic [N-1:0]     frm_cmplt;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  always #5 clk = ~clk;

  uart_tx_frame_arb #(.NUM_REQ(N), .FRM_BYTES(B)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .frm_data(frm_data), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data), .gnt(gnt), .frm_cmplt(frm_cmplt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trmt"}, trmt, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_cmplt"}, frm_cmplt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    tx_done = 1'b0;
    #1;
    chk_all_zero("rst");
    step();
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  // Called in an IDLE cycle with req non-zero; returns in the frm_cmplt cycle.
  task automatic do_frame(input bit inject);
    int           w;
    int           n;
    logic [FW-1:0] frame;
    logic [7:0]   exp_b;
    w     = pick(req, ptr_m);
    frame = frm_data[w*FW +: FW];
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    step();
    chk("gnt", gnt, oh(w));
    chk("busy", busy, 1);
    chk("trmt_early", trmt, 0);
    chk("cmplt_pulse", frm_cmplt, 0);
    if (inject) begin
      for (int k = 0; k < N*FW; k++) frm_data[k] = 1'($urandom_range(0, 1));
      req     = N'($urandom);
      tx_done = 1'b1;
    end
    step();
    tx_done = 1'b0;
    for (int b = 0; b < B; b++) begin
      exp_b = frame[FW-1-8*b -: 8];
      chk("trmt", trmt, 1);
      chk("tx_data", tx_data, exp_b);
      chk("gnt_hold", gnt, oh(w));
      n = $urandom_range(0, 3);
      repeat (n) begin
        step();
        chk("trmt_once", trmt, 0);
        chk("data_hold", tx_data, exp_b);
        chk("wait_busy", busy, 1);
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (b == B - 1) begin
        chk("cmplt", frm_cmplt, oh(w));
        chk("gnt_clr", gnt, 0);
        chk("busy_clr", busy, 0);
        chk("trmt_end", trmt, 0);
      end else begin
        chk("trmt_gap", trmt, 0);
        chk("send_busy", busy, 1);
        step();
      end
    end
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    do_reset();
    step();
    chk_all_zero("post_rst");

    // Single requester, frame 0xA55A.
    frm_data[0 +: FW] = 16'hA55A;
    req = 2'b01;
    do_frame(1'b0);
    req = 2'b00;
    step();
    chk("idle_after_cmplt", frm_cmplt, 0);
    chk("idle_after_busy", busy, 0);

    // tx_done while idle must not start anything.
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("idle_txd_trmt", trmt, 0);
    chk("idle_txd_busy", busy, 0);
    step();
    chk("idle_txd_trmt2", trmt, 0);

    // Both requesting from reset: four alternating frames, back to back.
    do_reset();
    frm_data = {16'h3344, 16'h1122};
    req = 2'b11;
    repeat (4) do_frame(1'b0);

    // Frame capture and tx_done in SEND are ignored.
    do_reset();
    frm_data = {16'h3344, 16'hA55A};
    req = 2'b01;
    do_frame(1'b1);
    req = 2'b00;
    step();

    // Reset mid-frame after the first byte.
    do_reset();
    frm_data = {16'h3344, 16'hBEEF};
    req = 2'b11;
    step();
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    step();
    chk("mid_rst_cmplt", frm_cmplt, 0);
    rst_n = 1'b1;
    ptr_m = 0;
    do_frame(1'b0);

    // Randomized request patterns and frame contents.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N*FW; k++) frm_data[k] = 1'($urandom_range(0, 1));
      req = N'($urandom);
      if (req == '0) begin
        step();
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_gnt", gnt, 0);
        chk("rnd_idle_cmplt", frm_cmplt, 0);
      end else begin
        do_frame(1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
